// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised sequence detector.
// Next-state tables are built at elaboration from these functions.
package seq_det_pkg;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Longest proper border of the whole pattern.
  function automatic int seq_border(
    input logic [15:0] pattern,
    input int          len
  );
    int  res;
    logic ok;
    res = 0;
    for (int j = 1; j < len; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (pattern[len-1-i] != pattern[j-1-i])
          ok = 1'b0;
      end
      if (ok) res = j;
    end
    return res;
  endfunction

  // KMP step: longest prefix that is a suffix of (P[0..k-1], b).
  function automatic int seq_next(
    input logic [15:0] pattern,
    input int          len,
    input int          k,
    input logic        b,
    input logic        overlap
  );
    int   kk;
    int   pos;
    int   res;
    logic ok;
    logic c;
    kk = k;
    if (kk >= len)
      kk = overlap ? seq_border(pattern, len) : 0;
    res = 0;
    for (int j = 1; j <= kk + 1; j++) begin
      if (j <= len) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          pos = kk + 1 - j + i;
          c = (pos < kk) ? pattern[len-1-pos] : b;
          if (c != pattern[len-1-i])
            ok = 1'b0;
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by rst.
// Used as the detection counter of the sequence detector.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/moore_seq_detect_param.sv
// Parametrised Moore serial sequence detector with clock enable
// and saturating detection counter.
module moore_seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int          PAT_LEN = 5,
  parameter logic [15:0] PATTERN = 16'b11011,
  parameter bit          OVERLAP = 1'b0,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] det_cnt
);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $error("moore_seq_detect_param: illegal PAT_LEN %0d", PAT_LEN);
  end

  localparam int STATE_W = clog2(PAT_LEN + 1);
  localparam int DEPTH   = 1 << STATE_W;
  localparam logic [STATE_W-1:0] DET = STATE_W'(PAT_LEN);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] nxt;
  logic [STATE_W-1:0] nxt_tab [DEPTH][2];
  logic               inc;

  // Unreachable encodings above PAT_LEN fall back to state 0.
  for (genvar s = 0; s < DEPTH; s++) begin : g_st
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int NX = (s <= PAT_LEN) ?
        seq_next(PATTERN, PAT_LEN, s, (b != 0), OVERLAP) : 0;
      assign nxt_tab[s][b] = STATE_W'(NX);
    end
  end

  assign nxt = nxt_tab[state][in];
  assign inc = en && (nxt == DET);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      out   <= 1'b0;
    end else if (en) begin
      state <= nxt;
      out   <= (nxt == DET);
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc),
    .cnt (det_cnt)
  );

endmodule
